// File: rtl/tetris_line_clear_pkg.sv
// +----------------------------------------------------------------------+
// | tetris_line_clear_pkg: board geometry defaults, FSM states, helpers  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package tetris_line_clear_pkg;

  localparam int ROWS_DEFAULT = 20;
  localparam int COLS_DEFAULT = 10;

  typedef enum logic [2:0] {IDLE, READ, CHECK, FILL, DONE} lc_state_t;

  typedef logic [COLS_DEFAULT-1:0] row_t;

  function automatic logic [15:0] sat16_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetris_line_clear_if.sv
// +----------------------------------------------------------------------+
// | tetris_line_clear_if: lock handshake, board RAM port, event outputs  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface tetris_line_clear_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  localparam int ROW_W = $clog2(ROWS);

  logic             lock_valid;
  logic             busy;
  logic [ROW_W-1:0] rd_addr;
  logic [COLS-1:0]  rd_data;
  logic             wr_en;
  logic [ROW_W-1:0] wr_addr;
  logic [COLS-1:0]  wr_data;
  logic             done;
  logic [ROW_W:0]   lines_cleared;
  logic [15:0]      lines_total;
  logic             tetromino_locked;
  logic             line_cleared;

  modport master (
    input  lock_valid, rd_data,
    output busy, rd_addr, wr_en, wr_addr, wr_data, done,
           lines_cleared, lines_total, tetromino_locked, line_cleared
  );

  modport slave (
    output lock_valid, rd_data,
    input  busy, rd_addr, wr_en, wr_addr, wr_data, done,
           lines_cleared, lines_total, tetromino_locked, line_cleared
  );

endinterface

`default_nettype wire

// File: rtl/tetris_line_clear.sv
// +----------------------------------------------------------------------+
// | tetris_line_clear: bottom-up full-row removal and board compaction   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tetris_line_clear
  import tetris_line_clear_pkg::*;
#(
  parameter int ROWS = ROWS_DEFAULT,
  parameter int COLS = COLS_DEFAULT
) (
  input  wire                  clk,
  input  wire                  reset,
  tetris_line_clear_if.master  bus
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] c_bottom = ROW_W'(ROWS - 1);

  lc_state_t        r_state, w_state_next;
  logic [ROW_W-1:0] r_src, w_src_next;
  logic [ROW_W-1:0] r_dst, w_dst_next;
  logic [ROW_W:0]   r_cnt, w_cnt_next;
  logic [ROW_W:0]   r_lines_cleared;
  logic [15:0]      r_lines_total;

  logic             w_wr_en;
  logic [COLS-1:0]  w_wr_data;
  logic             w_done;
  logic             w_line_cleared;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_src           <= '0;
      r_dst           <= '0;
      r_cnt           <= '0;
      r_lines_cleared <= '0;
      r_lines_total   <= '0;
    end else begin
      r_state <= w_state_next;
      r_src   <= w_src_next;
      r_dst   <= w_dst_next;
      r_cnt   <= w_cnt_next;
      if (r_state == DONE) begin
        r_lines_cleared <= r_cnt;
        r_lines_total   <= sat16_add(r_lines_total, 16'(r_cnt));
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_src_next     = r_src;
    w_dst_next     = r_dst;
    w_cnt_next     = r_cnt;
    w_wr_en        = 1'b0;
    w_wr_data      = '0;
    w_done         = 1'b0;
    w_line_cleared = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.lock_valid) begin
          w_src_next   = c_bottom;
          w_dst_next   = c_bottom;
          w_cnt_next   = '0;
          w_state_next = READ;
        end
      end
      READ: w_state_next = CHECK;
      CHECK: begin
        if (&bus.rd_data) begin
          w_cnt_next = r_cnt + (ROW_W+1)'(1);
        end else begin
          // A kept row that has not moved yet needs no write-back.
          if (r_src != r_dst) begin
            w_wr_en   = 1'b1;
            w_wr_data = bus.rd_data;
          end
          w_dst_next = r_dst - ROW_W'(1);
        end
        if (r_src == '0) begin
          w_state_next = (w_cnt_next != '0) ? FILL : DONE;
        end else begin
          w_src_next   = r_src - ROW_W'(1);
          w_state_next = READ;
        end
      end
      FILL: begin
        w_wr_en = 1'b1;
        if (r_dst == '0) w_state_next = DONE;
        else             w_dst_next   = r_dst - ROW_W'(1);
      end
      DONE: begin
        w_done         = 1'b1;
        w_line_cleared = (r_cnt != '0);
        w_state_next   = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.busy             = (r_state != IDLE);
  assign bus.rd_addr          = r_src;
  assign bus.wr_en            = w_wr_en;
  assign bus.wr_addr          = r_dst;
  assign bus.wr_data          = w_wr_data;
  assign bus.done             = w_done;
  assign bus.tetromino_locked = w_done;
  assign bus.line_cleared     = w_line_cleared;
  assign bus.lines_cleared    = r_lines_cleared;
  assign bus.lines_total      = r_lines_total;

endmodule

`default_nettype wire

// File: tb/tb_tetris_line_clear.sv
// +----------------------------------------------------------------------+
// | tb_tetris_line_clear: directed bench with a behavioural board RAM    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tetris_line_clear;
  import tetris_line_clear_pkg::*;

  localparam int NR = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tetris_line_clear_if #(.ROWS(NR), .COLS(10)) bus ();

  tetris_line_clear #(.ROWS(NR), .COLS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  row_t       mem [0:31];
  row_t       brd [NR];
  row_t       exp_brd [NR];
  logic       ld_en;
  logic [4:0] ld_addr;
  row_t       ld_data;
  logic       mon_clr;
  int         wr_cnt, done_cnt, lc_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Synchronous 1R/1W board RAM plus event counters.
  always @(posedge clk) begin
    if (ld_en)           mem[ld_addr]     <= ld_data;
    else if (bus.wr_en)  mem[bus.wr_addr] <= bus.wr_data;
    bus.rd_data <= mem[bus.rd_addr];
    if (mon_clr) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      lc_cnt   <= 0;
    end else begin
      wr_cnt   <= wr_cnt   + int'(bus.wr_en);
      done_cnt <= done_cnt + int'(bus.done);
      lc_cnt   <= lc_cnt   + int'(bus.line_cleared);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_board();
    for (int i = 0; i < NR; i++) begin
      ld_en   = 1'b1;
      ld_addr = 5'(i);
      ld_data = brd[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic compact_model();
    int d;
    d = NR - 1;
    for (int s = NR - 1; s >= 0; s--) begin
      if (brd[s] != 10'h3FF) begin
        exp_brd[d] = brd[s];
        d--;
      end
    end
    for (int i = d; i >= 0; i--) exp_brd[i] = '0;
  endtask

  task automatic check_board(input string tag);
    int d;
    d = -1;
    for (int i = 0; i < NR; i++)
      if (d < 0 && mem[i] !== exp_brd[i]) d = i;
    n_checks++;
    assert (d == -1) else begin
      n_fail++;
      $error("FAIL %s board row %0d: observed %h expected %h", tag, d, mem[d], exp_brd[d]);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic run_pass(input string tag, input int exp_lat, input int exp_lines,
                          input logic exp_lc, input logic [15:0] exp_total, input int repulse_at);
    int n;
    bus.lock_valid = 1'b1;
    @(negedge clk);
    n = 1;
    bus.lock_valid = 1'b0;
    check({tag, ".busy_start"}, 32'(bus.busy), 32'd1);
    while (!bus.done && n < 200) begin
      bus.lock_valid = (n == repulse_at);
      @(negedge clk);
      n++;
    end
    bus.lock_valid = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".tetromino_locked"}, 32'(bus.tetromino_locked), 32'd1);
    check({tag, ".line_cleared"}, 32'(bus.line_cleared), 32'(exp_lc));
    @(negedge clk);
    check({tag, ".done_low"}, 32'(bus.done), 32'd0);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".lines_cleared"}, 32'(bus.lines_cleared), 32'(exp_lines));
    check({tag, ".lines_total"}, 32'(bus.lines_total), 32'(exp_total));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.lock_valid = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_clr = 1'b0;
    @(negedge clk);
    check("rst.busy",          32'(bus.busy), 32'd0);
    check("rst.done",          32'(bus.done), 32'd0);
    check("rst.wr_en",         32'(bus.wr_en), 32'd0);
    check("rst.rd_addr",       32'(bus.rd_addr), 32'd0);
    check("rst.lines_cleared", 32'(bus.lines_cleared), 32'd0);
    check("rst.lines_total",   32'(bus.lines_total), 32'd0);
    check("rst.pulses",        32'({bus.tetromino_locked, bus.line_cleared}), 32'd0);

    // Test 1: random board without full rows.
    for (int i = 0; i < NR; i++) brd[i] = row_t'($urandom_range(0, 1022));
    compact_model();
    load_board();
    clear_mon();
    run_pass("t1", 41, 0, 1'b0, 16'd0, 0);
    check("t1.writes", 32'(wr_cnt), 32'd0);
    check_board("t1");

    // Test 2: bottom row full, row 18 = 001.
    for (int i = 0; i < NR; i++) brd[i] = 10'h100 + row_t'(i);
    brd[19] = 10'h3FF;
    brd[18] = 10'h001;
    compact_model();
    load_board();
    clear_mon();
    run_pass("t2", 42, 1, 1'b1, 16'd1, 0);
    check("t2.writes", 32'(wr_cnt), 32'd20);
    check("t2.row19", 32'(mem[19]), 32'h001);
    check("t2.row0", 32'(mem[0]), 32'h000);
    check_board("t2");

    // Test 3: non-contiguous full rows 19,17,15,14.
    for (int i = 0; i < NR; i++) brd[i] = 10'h200 + row_t'(i);
    brd[19] = 10'h3FF; brd[17] = 10'h3FF; brd[15] = 10'h3FF; brd[14] = 10'h3FF;
    compact_model();
    load_board();
    clear_mon();
    run_pass("t3", 45, 4, 1'b1, 16'd5, 0);
    check("t3.writes", 32'(wr_cnt), 32'd20);
    check("t3.row19", 32'(mem[19]), 32'h212);
    check("t3.row4", 32'(mem[4]), 32'h200);
    check("t3.row3", 32'(mem[3]), 32'h000);
    check_board("t3");

    // Test 4: all rows full, running total pushed into saturation.
    for (int i = 0; i < NR; i++) brd[i] = 10'h3FF;
    compact_model();
    load_board();
    force dut.r_lines_total = 16'hFFF0;
    @(negedge clk);
    release dut.r_lines_total;
    clear_mon();
    run_pass("t4", 61, 20, 1'b1, 16'hFFFF, 0);
    check("t4.writes", 32'(wr_cnt), 32'd20);
    check_board("t4");

    // Test 5: reset during the CHECK of row 10.
    for (int i = 0; i < NR; i++) brd[i] = 10'h200 + row_t'(i);
    brd[19] = 10'h3FF; brd[17] = 10'h3FF; brd[15] = 10'h3FF; brd[14] = 10'h3FF;
    load_board();
    clear_mon();
    bus.lock_valid = 1'b1;
    @(negedge clk);
    bus.lock_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("t5.busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    mon_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mon_clr = 1'b0;
    check("t5.busy", 32'(bus.busy), 32'd0);
    check("t5.wr_en", 32'(bus.wr_en), 32'd0);
    check("t5.done", 32'(bus.done), 32'd0);
    repeat (60) @(negedge clk);
    check("t5.writes_after", 32'(wr_cnt), 32'd0);
    check("t5.done_count", 32'(done_cnt), 32'd0);
    check("t5.lc_count", 32'(lc_cnt), 32'd0);
    check("t5.lines_total", 32'(bus.lines_total), 32'd0);
    for (int i = 0; i < NR; i++) brd[i] = 10'h100 + row_t'(i);
    brd[19] = 10'h3FF;
    brd[18] = 10'h001;
    compact_model();
    load_board();
    run_pass("t5r", 42, 1, 1'b1, 16'd1, 0);
    check_board("t5r");

    // Test 6: lock re-pulsed mid-pass, then a second pass right after.
    load_board();
    clear_mon();
    run_pass("t6a", 42, 1, 1'b1, 16'd2, 10);
    repeat (10) @(negedge clk);
    check("t6a.done_count", 32'(done_cnt), 32'd1);
    check_board("t6a");
    load_board();
    run_pass("t6b", 42, 1, 1'b1, 16'd3, 0);
    check("t6.done_count", 32'(done_cnt), 32'd2);
    check("t6.lc_count", 32'(lc_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
